// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the multi-cycle divider.
// Imported by the interface, the trial-subtract step and the div_ctrl top.
package div_ctrl_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  typedef logic [WIDTH-1:0]   RegBus;
  typedef logic [2*WIDTH-1:0] DoubleRegBus;

endpackage

// File: rtl/div_ctrl_if.sv
// Request/response bundle between the EX stage (master) and the divider (slave).
interface div_ctrl_if
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH = div_ctrl_pkg::WIDTH
);

  logic               start_i;
  logic               annul_i;
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               busy_o;
  logic               ready_o;
  logic [2*WIDTH-1:0] result_o;

  modport master (
    output start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    input  busy_o, ready_o, result_o
  );

  modport slave (
    input  start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    output busy_o, ready_o, result_o
  );

endinterface

// File: rtl/div_ctrl_step.sv
// One radix-2 restoring iteration: shift in the next dividend bit, trial-subtract
// the divisor and return the new partial remainder plus the quotient bit.
module div_ctrl_step
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH = div_ctrl_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] i_partRem,
  input  logic             i_dividendBit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_partRem,
  output logic             o_qBit
);

  logic [WIDTH:0]   w_shifted;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;

  assign w_shifted = {i_partRem, i_dividendBit};
  assign w_ge      = (w_shifted >= {1'b0, i_divisor});
  // When the trial succeeds the difference is below the divisor, so the low WIDTH bits are exact.
  assign w_diff    = w_shifted[WIDTH-1:0] - i_divisor;

  assign o_partRem = w_ge ? w_diff : w_shifted[WIDTH-1:0];
  assign o_qBit    = w_ge;

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle signed/unsigned 32-bit divider for DIV/DIVU, one quotient bit per cycle.
// Result is {remainder, quotient}; divide-by-zero returns zero without trapping.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH = div_ctrl_pkg::WIDTH,
  parameter int CNT_W = div_ctrl_pkg::CNT_W
) (
  input  logic     clk,
  input  logic     rst,
  div_ctrl_if.slave bus
);

  div_state_e         r_state;
  div_state_e         w_nextState;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_dividendQuot;
  logic [WIDTH-1:0]   r_divisor;
  logic [WIDTH-1:0]   r_partRem;
  logic               r_quotNeg;
  logic               r_remNeg;
  logic [2*WIDTH-1:0] r_result;

  logic               w_accept;
  logic               w_divZero;
  logic               w_lastIter;
  logic [WIDTH-1:0]   w_absA;
  logic [WIDTH-1:0]   w_absB;
  logic [WIDTH-1:0]   w_nextRem;
  logic               w_qBit;
  logic [WIDTH-1:0]   w_quotNext;
  logic [WIDTH-1:0]   w_finalQuot;
  logic [WIDTH-1:0]   w_finalRem;

  assign w_accept   = (r_state == DivFree) && bus.start_i && !bus.annul_i;
  assign w_divZero  = (bus.opdata2_i == '0);
  assign w_lastIter = (r_cnt == CNT_W'(WIDTH - 1));

  assign w_absA = (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
  assign w_absB = (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;

  div_ctrl_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_partRem    (r_partRem),
    .i_dividendBit(r_dividendQuot[WIDTH-1]),
    .i_divisor    (r_divisor),
    .o_partRem    (w_nextRem),
    .o_qBit       (w_qBit)
  );

  // Dividend bits leave at the MSB while quotient bits enter at the LSB of the same register.
  assign w_quotNext  = {r_dividendQuot[WIDTH-2:0], w_qBit};
  assign w_finalQuot = r_quotNeg ? -w_quotNext : w_quotNext;
  assign w_finalRem  = r_remNeg  ? -w_nextRem  : w_nextRem;

  always_ff @(posedge clk) begin
    if (rst) r_state <= DivFree;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    bus.busy_o  = 1'b0;
    bus.ready_o = DivResultNotReady;
    case (r_state)
      DivFree: begin
        if (w_accept) begin
          bus.busy_o  = 1'b1;
          w_nextState = w_divZero ? DivByZero : DivOn;
        end
      end
      DivByZero: begin
        bus.busy_o  = 1'b1;
        w_nextState = bus.annul_i ? DivFree : DivEnd;
      end
      DivOn: begin
        bus.busy_o = 1'b1;
        if (bus.annul_i)     w_nextState = DivFree;
        else if (w_lastIter) w_nextState = DivEnd;
      end
      DivEnd: begin
        bus.ready_o = DivResultReady;
        if (bus.start_i == DivStop) w_nextState = DivFree;
      end
      default: w_nextState = DivFree;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt          <= '0;
      r_dividendQuot <= '0;
      r_divisor      <= '0;
      r_partRem      <= '0;
      r_quotNeg      <= 1'b0;
      r_remNeg       <= 1'b0;
      r_result       <= '0;
    end else begin
      case (r_state)
        DivFree: begin
          if (w_accept && !w_divZero) begin
            r_cnt          <= '0;
            r_dividendQuot <= w_absA;
            r_divisor      <= w_absB;
            r_partRem      <= '0;
            r_quotNeg      <= bus.signed_div_i & (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
            r_remNeg       <= bus.signed_div_i & bus.opdata1_i[WIDTH-1];
          end
        end
        DivByZero: begin
          r_cnt <= '0;
          if (!bus.annul_i) r_result <= '0;
        end
        DivOn: begin
          if (bus.annul_i) begin
            r_cnt <= '0;
          end else begin
            r_partRem      <= w_nextRem;
            r_dividendQuot <= w_quotNext;
            if (w_lastIter) begin
              r_cnt    <= '0;
              r_result <= {w_finalRem, w_finalQuot};
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.result_o = r_result;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl: latency, results, divide-by-zero, annul and reset.
module tb_div_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   passCnt  = 0;
  int   totalCnt = 0;

  div_ctrl_if bus ();

  div_ctrl dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues a divide in the current (FREE) cycle and steps until ready_o, scrambling the live operands after acceptance.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        output int lat, output int busyCnt, output int lastBusy);
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b0;
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    #1;
    lat      = -1;
    busyCnt  = 0;
    lastBusy = -1;
    for (int c = 0; c < 60; c++) begin
      if (bus.ready_o === 1'b1) begin
        lat = c;
        break;
      end
      if (bus.busy_o === 1'b1) begin
        busyCnt++;
        lastBusy = c;
      end
      tick();
      bus.opdata1_i    = 32'hDEADBEEF;
      bus.opdata2_i    = 32'h00000000;
      bus.signed_div_i = ~sgn;
      #1;
    end
  endtask

  task automatic release_op();
    bus.start_i = 1'b0;
    tick();
    #1;
  endtask

  task automatic test_reset();
    rst              = 1'b1;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    totalCnt++;
    if (bus.ready_o !== 1'b0) $display("[TB] FAIL reset_ready got %b want 0", bus.ready_o);
    else passCnt++;
    totalCnt++;
    if (bus.busy_o !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", bus.busy_o);
    else passCnt++;
    totalCnt++;
    if (bus.result_o !== 64'h0) $display("[TB] FAIL reset_result got %h want 0", bus.result_o);
    else passCnt++;
  endtask

  task automatic test_unsigned();
    int lat, bc, lb, held;
    run_op(32'd100, 32'd7, 1'b0, lat, bc, lb);
    totalCnt++;
    if (lat !== 33) $display("[TB] FAIL udiv_latency got %0d want 33", lat);
    else passCnt++;
    totalCnt++;
    if (bc !== 33 || lb !== 32) $display("[TB] FAIL udiv_busy got count %0d last %0d want 33/32", bc, lb);
    else passCnt++;
    totalCnt++;
    if (bus.result_o !== 64'h00000002_0000000E) $display("[TB] FAIL udiv_result got %h want 000000020000000e", bus.result_o);
    else passCnt++;
    totalCnt++;
    if (bus.busy_o !== 1'b0) $display("[TB] FAIL udiv_end_busy got %b want 0", bus.busy_o);
    else passCnt++;
    held = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      if (bus.ready_o === 1'b1 && bus.result_o === 64'h00000002_0000000E) held++;
    end
    totalCnt++;
    if (held !== 5) $display("[TB] FAIL udiv_end_hold got %0d stable cycles want 5", held);
    else passCnt++;
    release_op();
    totalCnt++;
    if (bus.ready_o !== 1'b0) $display("[TB] FAIL udiv_release_ready got %b want 0", bus.ready_o);
    else passCnt++;
    totalCnt++;
    if (bus.result_o !== 64'h00000002_0000000E) $display("[TB] FAIL udiv_release_result got %h want 000000020000000e", bus.result_o);
    else passCnt++;
  endtask

  task automatic test_signed();
    int lat, bc, lb;
    run_op(32'hFFFFFFF9, 32'h00000002, 1'b1, lat, bc, lb);
    totalCnt++;
    if (lat !== 33) $display("[TB] FAIL sdiv_neg_latency got %0d want 33", lat);
    else passCnt++;
    totalCnt++;
    if (bus.result_o !== 64'hFFFFFFFF_FFFFFFFD) $display("[TB] FAIL sdiv_neg_result got %h want fffffffffffffffd", bus.result_o);
    else passCnt++;
    release_op();
    run_op(32'h00000007, 32'hFFFFFFFE, 1'b1, lat, bc, lb);
    totalCnt++;
    if (bus.result_o !== 64'h00000001_FFFFFFFD) $display("[TB] FAIL sdiv_negdivisor_result got %h want 00000001fffffffd", bus.result_o);
    else passCnt++;
    release_op();
  endtask

  task automatic test_div_zero();
    int lat, bc, lb;
    run_op(32'd5, 32'd0, 1'b1, lat, bc, lb);
    totalCnt++;
    if (lat !== 2) $display("[TB] FAIL divzero_s_latency got %0d want 2", lat);
    else passCnt++;
    totalCnt++;
    if (bc !== 2 || lb !== 1) $display("[TB] FAIL divzero_s_busy got count %0d last %0d want 2/1", bc, lb);
    else passCnt++;
    totalCnt++;
    if (bus.result_o !== 64'h0) $display("[TB] FAIL divzero_s_result got %h want 0", bus.result_o);
    else passCnt++;
    release_op();
    run_op(32'd5, 32'd0, 1'b0, lat, bc, lb);
    totalCnt++;
    if (lat !== 2 || bc !== 2) $display("[TB] FAIL divzero_u_timing got latency %0d busy %0d want 2/2", lat, bc);
    else passCnt++;
    totalCnt++;
    if (bus.result_o !== 64'h0) $display("[TB] FAIL divzero_u_result got %h want 0", bus.result_o);
    else passCnt++;
    release_op();
  endtask

  task automatic test_annul();
    int lat, bc, lb;
    logic readySeen;
    logic [63:0] prevResult;
    prevResult = bus.result_o;
    readySeen  = 1'b0;
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'hFFFFFFFF;
    bus.opdata2_i    = 32'd3;
    #1;
    for (int c = 0; c < 10; c++) begin
      if (bus.ready_o === 1'b1) readySeen = 1'b1;
      tick();
    end
    bus.annul_i = 1'b1;
    tick();
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    #1;
    totalCnt++;
    if (bus.busy_o !== 1'b0) $display("[TB] FAIL annul_busy got %b want 0", bus.busy_o);
    else passCnt++;
    totalCnt++;
    if (bus.ready_o !== 1'b0 || readySeen !== 1'b0) $display("[TB] FAIL annul_ready got %b seen %b want 0/0", bus.ready_o, readySeen);
    else passCnt++;
    totalCnt++;
    if (bus.result_o !== prevResult) $display("[TB] FAIL annul_result got %h want %h", bus.result_o, prevResult);
    else passCnt++;
    tick();
    run_op(32'd9, 32'd3, 1'b0, lat, bc, lb);
    totalCnt++;
    if (lat !== 33) $display("[TB] FAIL annul_restart_latency got %0d want 33", lat);
    else passCnt++;
    totalCnt++;
    if (bus.result_o !== 64'h00000000_00000003) $display("[TB] FAIL annul_restart_result got %h want 0000000000000003", bus.result_o);
    else passCnt++;
    bus.annul_i = 1'b1;
    tick();
    #1;
    totalCnt++;
    if (bus.ready_o !== 1'b1) $display("[TB] FAIL annul_in_end got ready %b want 1", bus.ready_o);
    else passCnt++;
    bus.annul_i = 1'b0;
    release_op();
  endtask

  task automatic test_extremes();
    int lat, bc, lb;
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, lat, bc, lb);
    totalCnt++;
    if (bus.result_o !== 64'h00000000_80000000) $display("[TB] FAIL overflow_result got %h want 0000000080000000", bus.result_o);
    else passCnt++;
    release_op();
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, lat, bc, lb);
    totalCnt++;
    if (bus.result_o !== 64'h00000000_FFFFFFFF) $display("[TB] FAIL umax_by_one_result got %h want 00000000ffffffff", bus.result_o);
    else passCnt++;
    release_op();
    run_op(32'h00000001, 32'hFFFFFFFF, 1'b0, lat, bc, lb);
    totalCnt++;
    if (lat !== 33) $display("[TB] FAIL one_by_umax_latency got %0d want 33", lat);
    else passCnt++;
    totalCnt++;
    if (bus.result_o !== 64'h00000001_00000000) $display("[TB] FAIL one_by_umax_result got %h want 0000000100000000", bus.result_o);
    else passCnt++;
    release_op();
  endtask

  task automatic test_reset_mid();
    logic readySeen;
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'hFFFFFFFF;
    bus.opdata2_i    = 32'd3;
    #1;
    for (int c = 0; c < 20; c++) tick();
    totalCnt++;
    if (bus.busy_o !== 1'b1) $display("[TB] FAIL midreset_busy_before got %b want 1", bus.busy_o);
    else passCnt++;
    rst         = 1'b1;
    bus.start_i = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    totalCnt++;
    if (bus.ready_o !== 1'b0 || bus.busy_o !== 1'b0) $display("[TB] FAIL midreset_ctrl got ready %b busy %b want 0/0", bus.ready_o, bus.busy_o);
    else passCnt++;
    totalCnt++;
    if (bus.result_o !== 64'h0) $display("[TB] FAIL midreset_result got %h want 0", bus.result_o);
    else passCnt++;
    readySeen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.ready_o === 1'b1) readySeen = 1'b1;
    end
    totalCnt++;
    if (readySeen !== 1'b0) $display("[TB] FAIL midreset_no_ready got %b want 0", readySeen);
    else passCnt++;
    bus.start_i   = 1'b1;
    bus.annul_i   = 1'b1;
    bus.opdata2_i = 32'd3;
    #1;
    totalCnt++;
    if (bus.busy_o !== 1'b0) $display("[TB] FAIL start_annul_busy got %b want 0", bus.busy_o);
    else passCnt++;
    tick();
    #1;
    totalCnt++;
    if (bus.busy_o !== 1'b0) $display("[TB] FAIL start_annul_not_accepted got busy %b want 0", bus.busy_o);
    else passCnt++;
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_annul();
    test_extremes();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
